lfsr_rand_gen: RTL and testbench

- Parametrised pseudo-random number generator for game-event selection, e.g. which lane or tile spawns next.
- Galois LFSR of configurable width with a request/acknowledge handshake and seed loading.
- Rejection sampling returns values uniformly in 0..MAX_VAL, with an optional no-immediate-repeat mode.
- Sits between the game controller, which issues requests, and the spawn/lane logic, which consumes `rand_out`. Supersedes the fixed 4-bit generator.

---
 rtl/rand_pkg.sv | 45 ++++
 rtl/lfsr_core.sv | 45 ++++
 rtl/lfsr_rand_gen.sv | 139 +++++++++++++
 tb/tb_lfsr_rand_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types, LFSR tap table and parameter legality check for the
// game-event random number generator.
package rand_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StHold
    } state_e;

    localparam int unsigned TryW = 4;

    // Right-shifting Galois masks giving a maximal-length sequence.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hB400;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned out_w,
                                     input int unsigned max_val, input int unsigned max_tries);
        bit ok;
        ok = 1'b1;
        if (width < 3 || width > 16) ok = 1'b0;
        if (out_w < 2 || out_w > width) ok = 1'b0;
        if (max_val + 1 < (32'd1 << (out_w - 1)) || max_val > (32'd1 << out_w) - 1) ok = 1'b0;
        if (max_tries < 1 || max_tries > 15) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with seed loading; a zero seed is replaced by 1 so the
// lock-up state can never be entered.
module lfsr_core
    import rand_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] Taps = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_nz;
    logic [WIDTH-1:0] next_state;

    assign seed_nz    = (seed == '0) ? One : seed;
    assign next_state = state_q[0] ? ((state_q >> 1) ^ Taps) : (state_q >> 1);

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_nz;
        end else if (step) begin
            state_d = next_state;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= One;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Request/acknowledge random value generator: draws LFSR candidates, rejects
// out-of-range (and optionally repeated) values, folds after MAX_TRIES rejects.
module lfsr_rand_gen
    import rand_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned MAX_VAL   = 9,
    parameter int unsigned MAX_TRIES = 4,
    parameter int unsigned NO_REPEAT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             free_run,
    input  logic             req,
    input  logic             ack,
    output logic [OUT_W-1:0] rand_out,
    output logic             valid,
    output logic             busy,
    output logic             fallback,
    output logic [WIDTH-1:0] lfsr_state
);

    if (!params_ok(WIDTH, OUT_W, MAX_VAL, MAX_TRIES)) begin : g_bad_params
        $error("lfsr_rand_gen: illegal parameter combination");
    end

    localparam logic [OUT_W-1:0] MaxVal  = OUT_W'(MAX_VAL);
    localparam logic [OUT_W-1:0] Modulus = OUT_W'(MAX_VAL + 1);
    localparam logic [TryW-1:0]  LastTry = TryW'(MAX_TRIES - 1);

    state_e           state_q, state_d;
    logic [TryW-1:0]  tries_q, tries_d;
    logic [OUT_W-1:0] rand_out_q, rand_out_d;
    logic [OUT_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             fallback_q, fallback_d;

    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_s;
    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic             accept;

    lfsr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (seed_load),
        .step   (lfsr_step),
        .seed   (seed),
        .state  (lfsr_s)
    );

    assign cand     = lfsr_s[OUT_W-1:0];
    assign in_range = (cand <= MaxVal);
    assign accept   = in_range && ((NO_REPEAT == 0) || (cand != last_q));

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        rand_out_d = rand_out_q;
        last_d     = last_q;
        fallback_d = fallback_q;
        lfsr_step  = 1'b0;

        if (seed_load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    lfsr_step = free_run;
                    if (req) begin
                        state_d = StDraw;
                        tries_d = '0;
                    end
                end
                StDraw: begin
                    lfsr_step = 1'b1;
                    if (accept) begin
                        rand_out_d = cand;
                        last_d     = cand;
                        fallback_d = 1'b0;
                        state_d    = StHold;
                    end else if (tries_q == LastTry) begin
                        // Fold may repeat the last value; delivery is guaranteed here.
                        rand_out_d = in_range ? cand : (cand - Modulus);
                        last_d     = in_range ? cand : (cand - Modulus);
                        fallback_d = 1'b1;
                        state_d    = StHold;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
                StHold: begin
                    lfsr_step = free_run;
                    if (ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        valid_d = (state_d == StHold);
        busy_d  = (state_d == StDraw);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= StIdle;
            tries_q    <= '0;
            rand_out_q <= '0;
            last_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            rand_out_q <= rand_out_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            fallback_q <= fallback_d;
        end
    end

    assign rand_out   = rand_out_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign fallback   = fallback_q;
    assign lfsr_state = lfsr_s;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: three instances (default, MAX_TRIES=1, NO_REPEAT=1)
// checked against a draw-level reference model.
module tb_lfsr_rand_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       seed_load;
    logic       free_run;
    logic [7:0] seed;
    logic       req [3];
    logic       ack [3];
    logic [3:0] rand_out [3];
    logic       valid [3];
    logic       busy [3];
    logic       fallback [3];
    logic [7:0] lfsr_state [3];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int unsigned mt [3] = '{4, 1, 4};
    bit          nr [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  ms [3];
    logic [3:0]  mlast [3];

    always #5 clk = ~clk;

    lfsr_rand_gen #(.WIDTH(8), .OUT_W(4), .MAX_VAL(9), .MAX_TRIES(4), .NO_REPEAT(0)) dut (
        .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .free_run(free_run),
        .req(req[0]), .ack(ack[0]), .rand_out(rand_out[0]), .valid(valid[0]), .busy(busy[0]),
        .fallback(fallback[0]), .lfsr_state(lfsr_state[0])
    );

    lfsr_rand_gen #(.WIDTH(8), .OUT_W(4), .MAX_VAL(9), .MAX_TRIES(1), .NO_REPEAT(0)) dut_fb (
        .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .free_run(free_run),
        .req(req[1]), .ack(ack[1]), .rand_out(rand_out[1]), .valid(valid[1]), .busy(busy[1]),
        .fallback(fallback[1]), .lfsr_state(lfsr_state[1])
    );

    lfsr_rand_gen #(.WIDTH(8), .OUT_W(4), .MAX_VAL(9), .MAX_TRIES(4), .NO_REPEAT(1)) dut_nr (
        .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .free_run(free_run),
        .req(req[2]), .ack(ack[2]), .rand_out(rand_out[2]), .valid(valid[2]), .busy(busy[2]),
        .fallback(fallback[2]), .lfsr_state(lfsr_state[2])
    );

    function automatic logic [7:0] lstep(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ms[k]    = 8'h01;
            mlast[k] = 4'h0;
        end
    endtask

    task automatic model_load(input logic [7:0] sd);
        for (int k = 0; k < 3; k++) ms[k] = (sd == 8'h00) ? 8'h01 : sd;
    endtask

    task automatic model_free(input int n);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < n; j++) ms[k] = lstep(ms[k]);
    endtask

    // One draw: try candidates (low nibble) until one is legal or tries run out.
    task automatic model_draw(input int i, output logic [3:0] v, output logic fb, output int draws);
        int unsigned c;
        draws = 0;
        v     = 4'h0;
        fb    = 1'b0;
        for (int t = 0; t < int'(mt[i]); t++) begin
            c = ms[i] % 16;
            ms[i] = lstep(ms[i]);
            draws++;
            if (c <= 9 && !(nr[i] && c == mlast[i])) begin
                v  = 4'(c);
                fb = 1'b0;
                break;
            end
            if (t == int'(mt[i]) - 1) begin
                v  = (c > 9) ? 4'(c - 10) : 4'(c);
                fb = 1'b1;
            end
        end
        mlast[i] = v;
    endtask

    task automatic draw(input int i, input string tag, output logic [3:0] v, output int n);
        logic fb;
        int   d;
        model_draw(i, v, fb, d);
        req[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (valid[i] !== 1'b1 && n < 20);
        req[i] = 1'b0;
        chk($sformatf("%s latency", tag), 32'(n), 32'(d + 1));
        chk($sformatf("%s value", tag), 32'(rand_out[i]), 32'(v));
        chk($sformatf("%s fallback", tag), 32'(fallback[i]), 32'(fb));
        chk($sformatf("%s lfsr", tag), 32'(lfsr_state[i]), 32'(ms[i]));
    endtask

    task automatic release_ack(input int i, input string tag);
        ack[i] = 1'b1;
        tick();
        ack[i] = 1'b0;
        chk($sformatf("%s valid drop", tag), 32'(valid[i]), 32'd0);
        chk($sformatf("%s busy idle", tag), 32'(busy[i]), 32'd0);
    endtask

    task automatic do_load(input logic [7:0] sd);
        seed      = sd;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_load(sd);
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk($sformatf("%s rand_out", tag), 32'(rand_out[i]), 32'd0);
        chk($sformatf("%s valid", tag), 32'(valid[i]), 32'd0);
        chk($sformatf("%s busy", tag), 32'(busy[i]), 32'd0);
        chk($sformatf("%s fallback", tag), 32'(fallback[i]), 32'd0);
        chk($sformatf("%s lfsr", tag), 32'(lfsr_state[i]), 32'd1);
    endtask

    initial begin
        logic [3:0] v;
        int         n;
        bit         flag;
        int         idx;
        int         burst;

        reset_n   = 1'b1;
        seed_load = 1'b0;
        free_run  = 1'b0;
        seed      = 8'h00;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0;
            ack[k] = 1'b0;
        end
        model_reset();
        repeat (3) tick();
        for (int k = 0; k < 3; k++) chk_reset(k, $sformatf("reset%0d", k));

        // First draw after reset
        reset_n = 1'b0;
        tick();
        draw(0, "first", v, n);
        chk("first const", 32'(rand_out[0]), 32'd1);
        chk("first at t+2", 32'(n), 32'd2);
        release_ack(0, "first");

        // Accept/reject sequence 1, 8, 7
        do_load(8'h01);
        chk("seed1 lfsr", 32'(lfsr_state[0]), 32'h01);
        draw(0, "seq1", v, n);
        chk("seq1 const", 32'(rand_out[0]), 32'd1);
        release_ack(0, "seq1");
        draw(0, "seq2", v, n);
        chk("seq2 const", 32'(rand_out[0]), 32'd8);
        release_ack(0, "seq2");
        draw(0, "seq3", v, n);
        chk("seq3 const", 32'(rand_out[0]), 32'd7);
        chk("seq3 at t+4", 32'(n), 32'd4);
        chk("seq3 lfsr const", 32'(lfsr_state[0]), 32'hB3);
        release_ack(0, "seq3");

        // Zero seed and full period
        do_load(8'h00);
        for (int k = 0; k < 3; k++) chk($sformatf("zero seed%0d", k), 32'(lfsr_state[k]), 32'd1);
        free_run = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (lfsr_state[0] == 8'h00) flag = 1'b1;
            if (k < 254 && lfsr_state[0] == 8'h01) flag = 1'b1;
        end
        free_run = 1'b0;
        model_free(255);
        chk("period no zero/short", 32'(flag), 32'd0);
        chk("period back to 1", 32'(lfsr_state[0]), 32'd1);
        chk("period inst2", 32'(lfsr_state[2]), 32'(ms[2]));

        // Fallback with MAX_TRIES=1
        do_load(8'h5C);
        draw(1, "fold", v, n);
        chk("fold const", 32'(rand_out[1]), 32'd2);
        chk("fold flag", 32'(fallback[1]), 32'd1);
        chk("fold at t+2", 32'(n), 32'd2);
        release_ack(1, "fold");

        // Seed load during a draw aborts it
        req[0] = 1'b1;
        tick();
        chk("abort busy", 32'(busy[0]), 32'd1);
        req[0] = 1'b0;
        do_load(8'h01);
        chk("abort busy low", 32'(busy[0]), 32'd0);
        chk("abort lfsr", 32'(lfsr_state[0]), 32'd1);
        chk("abort keeps rand_out", 32'(rand_out[0]), 32'd7);
        flag = 1'b0;
        repeat (4) begin
            tick();
            if (valid[0] !== 1'b0) flag = 1'b1;
        end
        chk("abort no valid", 32'(flag), 32'd0);
        draw(0, "after abort", v, n);
        chk("after abort const", 32'(rand_out[0]), 32'd1);

        // Hold with ack withheld while free-running
        free_run = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (rand_out[0] !== 4'd1 || valid[0] !== 1'b1) flag = 1'b1;
        end
        free_run = 1'b0;
        model_free(10);
        chk("hold stable", 32'(flag), 32'd0);
        chk("hold lfsr", 32'(lfsr_state[0]), 32'(ms[0]));
        ack[0] = 1'b1;
        req[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("ack+req valid", 32'(valid[0]), 32'd0);
        chk("ack+req idle", 32'(busy[0]), 32'd0);
        draw(0, "resample", v, n);
        release_ack(0, "resample");

        // Randomised rounds across all three instances
        for (int r = 0; r < 40; r++) begin
            idx = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) do_load(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
            burst = int'($urandom_range(0, 20));
            if (burst > 0) begin
                free_run = 1'b1;
                repeat (burst) tick();
                free_run = 1'b0;
                model_free(burst);
            end
            draw(idx, $sformatf("rnd%0d", r), v, n);
            repeat ($urandom_range(0, 3)) tick();
            release_ack(idx, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of a draw
        do_load(8'h5C);
        req[1] = 1'b1;
        req[0] = 1'b1;
        tick();
        tick();
        req[1] = 1'b0;
        req[0] = 1'b0;
        reset_n = 1'b1;
        #1;
        chk_reset(0, "async rst0");
        chk_reset(1, "async rst1");
        tick();
        reset_n = 1'b0;
        model_reset();
        draw(0, "post reset", v, n);
        chk("post reset const", 32'(rand_out[0]), 32'd1);
        release_ack(0, "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
